// File: rtl/i2si_rx_fifo_if.sv
// i2si_rx_fifo_if: source, control and read-side signals of the I2S receive FIFO
interface i2si_rx_fifo_if #(parameter int AW = 3);
  logic rf_bist_en;
  logic [31:0] i2si_bist_out_data;
  logic i2si_bist_out_xfc;
  logic [31:0] i2si_deser_data;
  logic i2si_deser_xfc;
  logic rf_fifo_clr;
  logic rf_flag_clr;
  logic [AW:0] rf_irq_thresh;
  logic rd_en;
  logic [31:0] rd_data;
  logic rd_ch;
  logic [AW:0] fifo_level;
  logic fifo_empty;
  logic fifo_full;
  logic ovf_sticky;
  logic unf_sticky;
  logic irq;
  modport master (
    output rf_bist_en, i2si_bist_out_data, i2si_bist_out_xfc, i2si_deser_data, i2si_deser_xfc,
           rf_fifo_clr, rf_flag_clr, rf_irq_thresh, rd_en,
    input  rd_data, rd_ch, fifo_level, fifo_empty, fifo_full, ovf_sticky, unf_sticky, irq
  );
  modport slave (
    input  rf_bist_en, i2si_bist_out_data, i2si_bist_out_xfc, i2si_deser_data, i2si_deser_xfc,
           rf_fifo_clr, rf_flag_clr, rf_irq_thresh, rd_en,
    output rd_data, rd_ch, fifo_level, fifo_empty, fifo_full, ovf_sticky, unf_sticky, irq
  );
endinterface

// File: rtl/i2si_rx_fifo.sv
// i2si_rx_fifo: source-selecting, channel-tagging FWFT receive FIFO with level flags and threshold irq
module i2si_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int AW = 3
) (
  input logic clk,
  input logic rst_n,
  i2si_rx_fifo_if.slave bus
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [32:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] lvl;
  logic src_q, ch_q, ovf_q, unf_q, irq_q;
  logic flush, push_req, push, pop, empty, full;
  logic [31:0] wdata;
  always_comb begin
    empty = lvl == '0;
    full = lvl == FULL;
    flush = bus.rf_fifo_clr | (bus.rf_bist_en != src_q);
    push_req = bus.rf_bist_en ? bus.i2si_bist_out_xfc : bus.i2si_deser_xfc;
    wdata = bus.rf_bist_en ? bus.i2si_bist_out_data : bus.i2si_deser_data;
    pop = bus.rd_en & ~empty & ~flush;
    push = push_req & (~full | pop) & ~flush;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      src_q <= 1'b0;
      ch_q <= 1'b0;
      wp <= '0;
      rp <= '0;
      lvl <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      src_q <= bus.rf_bist_en;
      ch_q <= flush ? 1'b0 : ch_q ^ push;
      wp <= flush ? '0 : wp + AW'(push);
      rp <= flush ? '0 : rp + AW'(pop);
      lvl <= flush ? '0 : (push & ~pop) ? lvl + 1'b1 : (pop & ~push) ? lvl - 1'b1 : lvl;
      ovf_q <= (push_req & full & ~pop & ~flush) | (ovf_q & ~bus.rf_flag_clr);
      unf_q <= (bus.rd_en & empty & ~flush) | (unf_q & ~bus.rf_flag_clr);
      irq_q <= (bus.rf_irq_thresh != '0) && (lvl >= bus.rf_irq_thresh);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= {ch_q, wdata};
  assign bus.rd_data = empty ? 32'h0 : mem[rp][31:0];
  assign bus.rd_ch = empty ? 1'b0 : mem[rp][32];
  assign bus.fifo_level = lvl;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full = full;
  assign bus.ovf_sticky = ovf_q;
  assign bus.unf_sticky = unf_q;
  assign bus.irq = irq_q;
endmodule

// File: tb/tb_i2si_rx_fifo.sv
// tb_i2si_rx_fifo: directed and random stimulus checked against a queue-based model of the receive FIFO
module tb_i2si_rx_fifo;
  logic clk = 0;
  logic rst_n = 0;
  int total = 0;
  int bad = 0;
  i2si_rx_fifo_if #(.AW(3)) bus ();
  i2si_rx_fifo #(.DEPTH(8), .AW(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [32:0] q[$];
  bit chm, srcm, ovfm, unfm, irqm;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic check_all();
    chk("level", 32'(bus.fifo_level), 32'(q.size()));
    chk("empty", 32'(bus.fifo_empty), 32'(q.size() == 0));
    chk("full", 32'(bus.fifo_full), 32'(q.size() == 8));
    chk("rd_data", bus.rd_data, q.size() ? q[0][31:0] : 32'h0);
    chk("rd_ch", 32'(bus.rd_ch), q.size() ? 32'(q[0][32]) : 32'h0);
    chk("ovf", 32'(bus.ovf_sticky), 32'(ovfm));
    chk("unf", 32'(bus.unf_sticky), 32'(unfm));
    chk("irq", 32'(bus.irq), 32'(irqm));
  endtask
  task automatic cyc(input bit bx, input bit dx, input bit rd, input bit clr, input bit fc, input logic [31:0] d);
    bit fl, pr, pp, ov_s, un_s;
    int lv0;
    bus.i2si_bist_out_xfc = bx;
    bus.i2si_deser_xfc = dx;
    bus.i2si_bist_out_data = ~d;
    bus.i2si_deser_data = d;
    bus.rd_en = rd;
    bus.rf_fifo_clr = clr;
    bus.rf_flag_clr = fc;
    lv0 = q.size();
    fl = clr || (bus.rf_bist_en !== srcm);
    pr = bus.rf_bist_en ? bx : dx;
    ov_s = 0;
    un_s = 0;
    if (fl) begin
      q.delete();
      chm = 0;
    end else begin
      pp = rd && lv0 > 0;
      un_s = rd && lv0 == 0;
      if (pp) void'(q.pop_front());
      if (pr) begin
        if (lv0 < 8 || pp) begin
          q.push_back({chm, bus.rf_bist_en ? ~d : d});
          chm = !chm;
        end else ov_s = 1;
      end
    end
    ovfm = ov_s || (ovfm && !fc);
    unfm = un_s || (unfm && !fc);
    irqm = bus.rf_irq_thresh != 0 && lv0 >= int'(bus.rf_irq_thresh);
    srcm = bus.rf_bist_en;
    @(posedge clk);
    #1;
    bus.i2si_bist_out_xfc = 0;
    bus.i2si_deser_xfc = 0;
    bus.rd_en = 0;
    bus.rf_fifo_clr = 0;
    bus.rf_flag_clr = 0;
    check_all();
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    bus.rf_bist_en = 0;
    bus.rf_irq_thresh = 0;
    bus.i2si_bist_out_xfc = 0;
    bus.i2si_deser_xfc = 0;
    bus.i2si_bist_out_data = 0;
    bus.i2si_deser_data = 0;
    bus.rd_en = 0;
    bus.rf_fifo_clr = 0;
    bus.rf_flag_clr = 0;
    #12;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1;
    idle();
    cyc(0, 1, 0, 0, 0, 32'h11);
    cyc(0, 1, 0, 0, 0, 32'h22);
    cyc(0, 1, 0, 0, 0, 32'h33);
    chk("t1_level", 32'(bus.fifo_level), 3);
    chk("t1_h0", {bus.rd_ch, bus.rd_data[30:0]}, {1'b0, 31'h11});
    cyc(0, 0, 1, 0, 0, 0);
    chk("t1_h1", {bus.rd_ch, bus.rd_data[30:0]}, {1'b1, 31'h22});
    cyc(0, 0, 1, 0, 0, 0);
    chk("t1_h2", {bus.rd_ch, bus.rd_data[30:0]}, {1'b0, 31'h33});
    cyc(0, 0, 1, 0, 0, 0);
    chk("t1_empty", 32'(bus.fifo_empty), 1);
    for (int i = 1; i <= 9; i++) cyc(0, 1, 0, 0, 0, 32'(i));
    chk("t2_full", {28'h0, bus.fifo_full, bus.fifo_level[2:0]}, 32'h8);
    chk("t2_level", 32'(bus.fifo_level), 8);
    chk("t2_ovf", 32'(bus.ovf_sticky), 1);
    for (int i = 1; i <= 8; i++) begin
      chk("t2_order", bus.rd_data, 32'(i));
      cyc(0, 0, 1, 0, 0, 0);
    end
    cyc(0, 0, 0, 0, 1, 0);
    chk("t2_ovf_clr", 32'(bus.ovf_sticky), 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0, 32'h100 + 32'(i));
    cyc(0, 1, 1, 0, 0, 32'h200);
    chk("t3_level", 32'(bus.fifo_level), 8);
    chk("t3_ovf", 32'(bus.ovf_sticky), 0);
    chk("t3_head", bus.rd_data, 32'h101);
    for (int i = 0; i < 7; i++) cyc(0, 0, 1, 0, 0, 0);
    chk("t3_tail", bus.rd_data, 32'h200);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    chk("t4_unf", 32'(bus.unf_sticky), 1);
    chk("t4_lvl", 32'(bus.fifo_level), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("t4_unf_clr", 32'(bus.unf_sticky), 0);
    cyc(0, 0, 1, 0, 1, 0);
    chk("t4_unf_pri", 32'(bus.unf_sticky), 1);
    cyc(0, 1, 1, 0, 1, 32'h44);
    chk("t4_emptypush", 32'(bus.fifo_level), 1);
    cyc(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0, 32'h50 + 32'(i));
    bus.rf_bist_en = 1;
    idle();
    chk("t5_flush", 32'(bus.fifo_level), 0);
    cyc(1, 1, 0, 0, 0, 32'hABC);
    chk("t5_bist", bus.rd_data, ~32'hABC);
    chk("t5_ch", 32'(bus.rd_ch), 0);
    cyc(0, 0, 1, 0, 0, 0);
    bus.rf_bist_en = 0;
    idle();
    bus.rf_irq_thresh = 4;
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0, 32'h60 + 32'(i));
    chk("t6_irq_n1", 32'(bus.irq), 0);
    idle();
    chk("t6_irq_n2", 32'(bus.irq), 1);
    cyc(0, 0, 1, 0, 0, 0);
    idle();
    chk("t6_irq_pop", 32'(bus.irq), 0);
    bus.rf_irq_thresh = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, 0, 0, 0, 32'h70 + 32'(i));
      chk("t6_irq_off", 32'(bus.irq), 0);
    end
    cyc(0, 1, 0, 0, 0, 32'h80);
    #2;
    rst_n = 0;
    #1;
    q.delete();
    chm = 0;
    srcm = 0;
    ovfm = 0;
    unfm = 0;
    irqm = 0;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1;
    check_all();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) bus.rf_bist_en = ~bus.rf_bist_en;
      if ($urandom_range(0, 29) == 0) bus.rf_irq_thresh = 4'($urandom_range(0, 8));
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 9) < 4,
          $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0, $urandom);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
